// File: rtl/mmc1_serial_writer.sv
// mmc1_serial_writer: serialises a register-load or shift-reset command
// into the CPU write sequence an MMC1 mapper expects, paced on the M2 enable.
module mmc1_serial_writer #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_reg,
  input  logic [4:0]  req_data,
  input  logic        req_reset,
  output logic [15:0] prg_ain,
  output logic [7:0]  prg_din,
  output logic        prg_write,
  output logic        busy,
  output logic        done
);

  localparam int unsigned GAP_W = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int unsigned BIT_W = 3;

  // A zero-length gap would let the mapper merge consecutive writes.
  if (GAP_CYCLES == 0) begin : g_gap_check
    $error("GAP_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state;
  logic [4:0]         data_q;
  logic               rst_q;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   nxt_bit;
  logic [GAP_W-1:0]   gap_cnt;

  assign nxt_bit   = bit_cnt + BIT_W'(1);
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Command sequencer: accept, one strobe per ce edge, mandatory gap, done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      data_q    <= 5'd0;
      rst_q     <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      prg_ain   <= 16'h0000;
      prg_din   <= 8'h00;
      prg_write <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            data_q    <= req_data;
            rst_q     <= req_reset;
            bit_cnt   <= '0;
            prg_write <= 1'b1;
            state     <= S_WRITE;
            if (req_reset) begin
              prg_ain <= 16'h8000;
              prg_din <= 8'h80;
            end else begin
              prg_ain <= {1'b1, req_reg, 13'h0000};
              prg_din <= {7'b0, req_data[0]};
            end
          end
        end
        S_WRITE: begin
          // The ce edge here is the one the mapper samples.
          if (ce) begin
            prg_write <= 1'b0;
            gap_cnt   <= GAP_W'(GAP_CYCLES);
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (ce) begin
            if (gap_cnt == GAP_W'(1)) begin
              if (!rst_q && (bit_cnt < BIT_W'(4))) begin
                bit_cnt   <= nxt_bit;
                prg_din   <= {7'b0, data_q[nxt_bit]};
                prg_write <= 1'b1;
                state     <= S_WRITE;
              end else begin
                prg_ain <= 16'h0000;
                prg_din <= 8'h00;
                done    <= 1'b1;
                state   <= S_IDLE;
              end
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
        end
        default: begin
          prg_write <= 1'b0;
          prg_ain   <= 16'h0000;
          prg_din   <= 8'h00;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Testbench for mmc1_serial_writer: randomized commands, scoreboard of
// expected mapper writes and completions, plus a small MMC1 shift model.
module tb_mmc1_serial_writer;

  localparam int unsigned GAP = 2;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_reg = 2'd0;
  logic [4:0]  req_data = 5'd0;
  logic        req_reset = 1'b0;
  logic [15:0] prg_ain;
  logic [7:0]  prg_din;
  logic        prg_write;
  logic        busy;
  logic        done;

  mmc1_serial_writer #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data), .req_reset(req_reset),
    .prg_ain(prg_ain), .prg_din(prg_din), .prg_write(prg_write),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [15:0] ain;
    logic [7:0]  din;
    int          id;
    bit          first;
  } wr_t;

  typedef struct {
    int         id;
    logic [1:0] r;
    logic [4:0] d;
    bit         rs;
    int         acc;
    bit         lat;
    int         nw;
  } cmd_t;

  wr_t  wq[$];
  cmd_t dq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mode = 0;
  int outstanding = 0;
  int wr_total = 0;
  int next_id = 0;

  logic [4:0] m_reg [4];
  logic [4:0] m_shift = 5'd0;
  int         m_cnt = 0;

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ce pattern: 0 = every clk, 1 = every third clk, 2 = random
  initial forever begin
    @(posedge clk);
    #1;
    case (mode)
      0: ce = 1'b1;
      1: ce = ((cyc % 3) == 0);
      default: ce = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [1:0] r, input logic [4:0] d, input logic rs);
    int   budget;
    cmd_t c;
    wr_t  w;
    budget = 0;
    @(posedge clk);
    #1;
    while (!req_ready) begin
      @(posedge clk);
      #1;
      budget++;
      if (budget > 3000) begin
        fails++;
        tests++;
        $display("FAIL ready_timeout: got busy expected idle");
        return;
      end
    end
    req_valid = 1'b1;
    req_reg   = r;
    req_data  = d;
    req_reset = rs;
    c.id = next_id++;
    c.r = r; c.d = d; c.rs = rs;
    c.lat = (mode == 0);
    c.nw = rs ? 1 : 5;
    for (int i = 0; i < c.nw; i++) begin
      w.id = c.id;
      w.first = (i == 0);
      w.ain = rs ? 16'h8000 : 16'h8000 + 16'(r) * 16'h2000;
      w.din = rs ? 8'h80 : 8'((d >> i) & 5'd1);
      wq.push_back(w);
    end
    @(posedge clk);
    #1;
    c.acc = cyc;
    dq.push_back(c);
    outstanding++;
    req_valid = 1'b0;
    req_reg   = 2'($urandom);
    req_data  = 5'($urandom);
    req_reset = 1'($urandom);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (outstanding != 0) begin
      @(posedge clk);
      budget++;
      if (budget > 3000) begin
        fails++;
        tests++;
        $display("FAIL drain_timeout: got %0d outstanding expected 0", outstanding);
        return;
      end
    end
    @(posedge clk);
  endtask

  // Monitor: checks bus protocol and pops the scoreboard on writes and done.
  initial begin
    int  hi_ce, low_ce;
    bit  have_prev, prev_pw, prev_done, have_last;
    logic [15:0] last_ain;
    logic [7:0]  last_din;
    wr_t  w;
    cmd_t c;
    hi_ce = 0; low_ce = 0; have_prev = 0; prev_pw = 0; prev_done = 0; have_last = 0;
    last_ain = '0; last_din = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hi_ce = 0; low_ce = 0; have_prev = 0; prev_pw = 0; prev_done = 0; have_last = 0;
        continue;
      end
      if (done) begin
        chk("done_single_pulse", 32'(prev_done), 0);
        if (dq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          c = dq.pop_front();
          chk("writes_left_at_done", 32'(wq.size() > 0 && wq[0].id == c.id), 0);
          if (c.lat) chk("latency", 32'(cyc - c.acc), 32'(c.nw * (1 + GAP)));
          if (c.rs) begin
            chk("mapper_shift_cleared", 32'(m_cnt), 0);
            chk("mapper_ctrl_bits", 32'(m_reg[0][3:2]), 3);
          end else begin
            chk("mapper_reg_loaded", 32'(m_reg[c.r]), 32'(c.d));
          end
          outstanding--;
        end
      end
      chk("busy", 32'(busy), 32'(outstanding != 0));
      chk("req_ready", 32'(req_ready), 32'(outstanding == 0));
      if (outstanding == 0) begin
        chk("idle_write", 32'(prg_write), 0);
        chk("idle_ain", 32'(prg_ain), 0);
        chk("idle_din", 32'(prg_din), 0);
      end
      if (prg_write && ce) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          w = wq.pop_front();
          chk("write_ain", 32'(prg_ain), 32'(w.ain));
          chk("write_din", 32'(prg_din), 32'(w.din));
          if (have_prev) begin
            if (w.first) chk("gap_between_cmds", 32'(low_ce >= GAP), 1);
            else         chk("gap_within_cmd", 32'(low_ce), 32'(GAP));
          end
        end
        if (prg_din[7]) begin
          m_shift = 5'd0;
          m_cnt = 0;
          m_reg[0] = m_reg[0] | 5'h0C;
        end else begin
          m_shift = {prg_din[0], m_shift[4:1]};
          m_cnt++;
          if (m_cnt == 5) begin
            m_reg[prg_ain[14:13]] = m_shift;
            m_shift = 5'd0;
            m_cnt = 0;
          end
        end
        wr_total++;
        have_prev = 1;
        low_ce = 0;
        last_ain = prg_ain;
        last_din = prg_din;
        have_last = 1;
      end
      if (prg_write) begin
        if (ce) hi_ce++;
      end else begin
        if (prev_pw) begin
          chk("strobe_one_ce", 32'(hi_ce), 1);
          hi_ce = 0;
        end
        if (ce) low_ce++;
        if (outstanding != 0 && have_last) begin
          chk("gap_hold_ain", 32'(prg_ain), 32'(last_ain));
          chk("gap_hold_din", 32'(prg_din), 32'(last_din));
        end
      end
      prev_pw = prg_write;
      prev_done = done;
    end
  end

  // Stimulus sequence
  initial begin
    int budget, w0;
    for (int i = 0; i < 4; i++) m_reg[i] = 5'd0;

    #1 reset = 1'b1;
    #3;
    chk("rst_write", 32'(prg_write), 0);
    chk("rst_ain", 32'(prg_ain), 0);
    chk("rst_din", 32'(prg_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(req_ready), 1);
    #2 reset = 1'b0;
    #2 clk_en = 1'b1;

    // directed: serial load, reset command, sparse ce
    mode = 0;
    issue(2'd3, 5'b10110, 1'b0);
    issue(2'd0, 5'b11111, 1'b1);
    drain();
    mode = 1;
    issue(2'd1, 5'h15, 1'b0);
    drain();

    // loopback into the shift model
    mode = 0;
    issue(2'd0, 5'h00, 1'b1);
    issue(2'd0, 5'b11011, 1'b0);
    issue(2'd3, 5'h07, 1'b0);
    drain();
    chk("loop_control", 32'(m_reg[0]), 32'h1B);
    chk("loop_prg_bank", 32'(m_reg[3]), 32'h07);

    // randomized commands under each ce pattern
    for (int m = 0; m < 3; m++) begin
      mode = m;
      for (int k = 0; k < 12; k++)
        issue(2'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0));
      drain();
    end

    // abort a load in flight with asynchronous reset
    mode = 0;
    w0 = wr_total;
    issue(2'd2, 5'($urandom), 1'b0);
    budget = 0;
    do begin
      @(negedge clk);
      #2;
      budget++;
    end while (!((wr_total - w0) >= 2 && prg_write) && budget < 200);
    if (budget >= 200) begin
      fails++;
      tests++;
      $display("FAIL abort_wait: got %0d writes expected 2", wr_total - w0);
    end
    #1 reset = 1'b1;
    wq.delete();
    dq.delete();
    outstanding = 0;
    #1;
    chk("abort_write", 32'(prg_write), 0);
    chk("abort_ain", 32'(prg_ain), 0);
    chk("abort_din", 32'(prg_din), 0);
    chk("abort_ready", 32'(req_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    issue(2'd0, 5'($urandom), 1'b1);
    issue(2'd2, 5'h19, 1'b0);
    drain();
    chk("recover_chr1", 32'(m_reg[2]), 32'h19);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmc1_serial_writer.md
# mmc1_serial_writer

Bus-side initiator for the MMC1 serial register interface. It accepts a register-load command and drives the CPU-side write sequence that the MMC1 mapper expects: five single-bit writes, LSB first, or a single reset write with bit 7 set. It sits between a host agent (test sequencer, savestate restore, or boot loader) and the mapper's `prg_ain`/`prg_write`/`prg_din` inputs. It paces writes on the M2 enable so the mapper's consecutive-write suppression never drops a bit.

## Interface
Parameters:
- GAP_CYCLES, 1, number of `ce` edges with `prg_write` low after every write. Must be ≥1; 0 is an elaboration error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  M2 enable; all bus progress happens only on `clk` edges with `ce`=1
- req_valid  in  1  command request
- req_ready  out  1  high only in IDLE
- req_reg  in  2  target register: 0 control ($8000), 1 chr_bank_0 ($A000), 2 chr_bank_1 ($C000), 3 prg_bank ($E000)
- req_data  in  5  register value
- req_reset  in  1  issue a shift-reset write instead of a load; has priority over `req_data`
- prg_ain  out  16  CPU address to the mapper
- prg_din  out  8  CPU write data to the mapper
- prg_write  out  1  CPU write strobe
- busy  out  1  state ≠ IDLE
- done  out  1  one-`clk` pulse when a command completes

## Operation
- States: IDLE, WRITE, GAP.
- **Accept.** A command is accepted on a `clk` edge with `req_valid & req_ready`. On that edge the block:
  - latches `req_reg`, `req_data` and `req_reset`;
  - sets bit_cnt=0;
  - moves to WRITE.
- **Address.** `prg_ain` = {1'b1, reg, 13'h0}. The same address is used for all five writes.
- **Data.**
  - Load: `prg_din` = {7'b0, data[bit_cnt]}.
  - Reset command: `prg_din` = 8'h80 and `prg_ain` = 16'h8000.
- **WRITE.**
  - `prg_write`=1, with address and data stable.
  - The state is held until a `clk` edge with `ce`=1; that edge is the one the mapper samples.
  - On that edge: go to GAP, set gap_cnt=GAP_CYCLES, and set `prg_write`=0.
- **GAP.**
  - `prg_write`=0; `prg_ain`/`prg_din` hold the last values.
  - gap_cnt decrements on each `ce` edge.
  - On the `ce` edge where gap_cnt==1:
    - a load with bit_cnt<4 increments bit_cnt and returns to WRITE;
    - otherwise the block goes to IDLE, and `done`=1 for the following `clk` cycle.
  - The gap after the final write is mandatory, so back-to-back commands also keep `prg_write` low for ≥GAP_CYCLES `ce` edges.
- **IDLE.** `prg_ain`=16'h0000, `prg_din`=8'h00, `prg_write`=0.
- **Reset command.** Exactly one write, then the gap, then done.
- **Strobe rule.** Each `prg_write` high interval covers exactly one `ce` edge.
- **Reset.** Asynchronous `reset` forces the following immediately, independent of `clk`, and any in-flight command is discarded without a `done` pulse:
  - state IDLE;
  - `prg_write`=0, `prg_ain`=0, `prg_din`=0;
  - `done`=0, `busy`=0;
  - `req_ready`=1.
- **Partial sequences.** The mapper may be left holding a partial shift. Hosts issue `req_reset` after any aborted sequence.
- **Input handling.** `req_data`/`req_reg` changes after acceptance are ignored. `req_valid` while busy is not accepted and is held by the host.

## Timing
- All outputs are registered except `req_ready` (= IDLE) and `busy`.
- **Latency with `ce`=1 every cycle.**
  - Load: `done` asserts 5×(1+GAP_CYCLES) edges after the accepting edge.
  - Reset command: `done` asserts 1+GAP_CYCLES edges after the accepting edge.
- **WRITE timing.** The first WRITE cycle starts the `clk` cycle after acceptance.
- **Sparse `ce`.** Each WRITE and GAP step stretches by the number of `clk` cycles until the next `ce` edge.
- **Next command.** `req_ready` rises in the same cycle `done` pulses, so a new command can be accepted on the next edge.
- **Counter widths.**
  - bit_cnt: 3 bits, range 0–4, never wraps.
  - gap_cnt: $clog2(GAP_CYCLES+1) bits.

## Test plan
- **Reset values.** Assert `reset` with `clk` stopped → `prg_write`=0, `prg_ain`=0, `prg_din`=0, `busy`=0, `done`=0, `req_ready`=1.
- **Serial load.** GAP_CYCLES=1, `ce`=1 constant, req_reg=3, req_data=5'b10110 →
  - `prg_write` high in cycles 1,3,5,7,9 after acceptance, at `prg_ain`=16'hE000;
  - `prg_din` bit 0 = 0,1,1,0,1 across those writes;
  - `done` pulses after edge 10.
- **Reset command.** req_reset=1 with req_data=5'b11111 → exactly one write of 8'h80 at 16'h8000; `done` after 2 edges; data ignored.
- **Sparse `ce`.** `ce` every 3rd `clk`, GAP_CYCLES=2, req_reg=1, data=5'h15 → a monitor counting `ce & prg_write` sees exactly 5 writes, and each write is followed by ≥2 `ce` edges with `prg_write` low.
- **Loopback.** Loopback into an MMC1 instance (enable=1): reset command, then control=5'b1_10_11, then prg_bank=5'h07 → mapper `control`==5'b11011 and `prg_bank`==5'h07; no write is swallowed by `delay_ctrl`.
- **Abort.** Assert `reset` asynchronously after the 2nd write of a load → `prg_write` falls without a `clk` edge, no `done` pulse, `req_ready`=1. A following reset command and load complete normally.
